// File: rtl/capture_window_pkg.sv
// Shared types and constants for the capture window and its trigger source.
// Frame-length defaults live beside the trigger period so they can be cross-checked.
package capture_window_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_CAPTURE = 2'd2
  } cw_state_e;

  localparam int DEFAULT_CAPTURE_LEN = 4096;
  localparam int DEFAULT_PRE_DELAY   = 0;
  localparam int TRIG_PERIOD         = 8192;

  // A nominal (gap-free) frame must end before the next periodic trigger arrives.
  function automatic bit frame_fits(input int len, input int dly, input int period);
    return (dly + len) < period;
  endfunction

endpackage

// File: rtl/capture_window_sat_counter.sv
// Event counter with an optional saturate-at-all-ones mode; wraps otherwise.
module capture_window_sat_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             inc_in,
  output logic [WIDTH-1:0] count_out
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_in && !(SATURATE && (&count_q))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/capture_window.sv
// Turns each accepted trigger into one fixed-length frame of ADC samples with
// registered valid/first/last framing, plus frame and dropped-trigger counters.
module capture_window
  import capture_window_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int CAPTURE_LEN  = DEFAULT_CAPTURE_LEN,
  parameter int PRE_DELAY    = DEFAULT_PRE_DELAY,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    enable_in,
  input  logic                    trigger_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  output logic [SAMPLE_WIDTH-1:0] data_out,
  output logic                    valid_out,
  output logic                    first_out,
  output logic                    last_out,
  output logic                    busy_out,
  output logic [CNT_WIDTH-1:0]    frame_count_out,
  output logic [CNT_WIDTH-1:0]    missed_count_out
);

  localparam int DLY_W = (PRE_DELAY > 0) ? $clog2(PRE_DELAY + 1) : 1;
  localparam int SCW   = $clog2(CAPTURE_LEN + 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(PRE_DELAY - 1);
  localparam logic [SCW-1:0]   LEN_C    = SCW'(CAPTURE_LEN);

  if (CAPTURE_LEN < 1) begin : g_bad_len
    $error("capture_window: CAPTURE_LEN must be at least 1");
  end
  if (!frame_fits(CAPTURE_LEN, PRE_DELAY, TRIG_PERIOD)) begin : g_frame_too_long
    $error("capture_window: frame does not fit inside the trigger period");
  end

  cw_state_e         state_q, state_d;
  logic [DLY_W-1:0]  delay_cnt_q, delay_cnt_d;
  logic [SCW-1:0]    sample_cnt_q, sample_cnt_d;
  logic [SCW-1:0]    sample_cnt_next;

  logic [SAMPLE_WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic first_q, first_d;
  logic last_q, last_d;
  logic busy_q, busy_d;
  logic beat;
  logic missed_inc;

  assign sample_cnt_next = sample_cnt_q + 1'b1;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      delay_cnt_q  <= '0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      delay_cnt_q  <= delay_cnt_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    delay_cnt_d  = delay_cnt_q;
    sample_cnt_d = sample_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger_in && enable_in) begin
          delay_cnt_d  = '0;
          sample_cnt_d = '0;
          state_d      = (PRE_DELAY > 0) ? ST_DELAY : ST_CAPTURE;
        end
      end
      ST_DELAY: begin
        delay_cnt_d = delay_cnt_q + 1'b1;
        if (delay_cnt_q == DLY_LAST) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // Invalid cycles simply stall; the frame only ends on its final sample.
        if (sample_valid_in) begin
          if (sample_cnt_next == LEN_C) begin
            state_d      = ST_IDLE;
            sample_cnt_d = '0;
          end else begin
            sample_cnt_d = sample_cnt_next;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    beat       = (state_q == ST_CAPTURE) && sample_valid_in;
    data_d     = beat ? sample_in : data_q;
    valid_d    = beat;
    first_d    = beat && (sample_cnt_q == '0);
    last_d     = beat && (sample_cnt_next == LEN_C);
    busy_d     = (state_d != ST_IDLE);
    missed_inc = trigger_in && (state_q != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  // Frame count advances on the same edge that registers last_out.
  capture_window_sat_counter #(
    .WIDTH   (CNT_WIDTH),
    .SATURATE(1'b0)
  ) u_frame_cnt (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .inc_in   (last_d),
    .count_out(frame_count_out)
  );

  capture_window_sat_counter #(
    .WIDTH   (CNT_WIDTH),
    .SATURATE(1'b1)
  ) u_missed_cnt (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .inc_in   (missed_inc),
    .count_out(missed_count_out)
  );

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign first_out = first_q;
  assign last_out  = last_q;
  assign busy_out  = busy_q;

endmodule

// File: tb/tb_capture_window.sv
// Drives two capture windows (no pre-delay and a 3-cycle pre-delay) from one
// stimulus stream and compares every output each cycle against a timeline model.
module tb_capture_window;

  localparam int SW  = 16;
  localparam int LEN = 8;
  localparam int CW  = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, en, trig, sv;
  logic [SW-1:0] smp;

  logic [SW-1:0] d0_data, d1_data;
  logic          d0_valid, d0_first, d0_last, d0_busy;
  logic          d1_valid, d1_first, d1_last, d1_busy;
  logic [CW-1:0] d0_fc, d0_mc, d1_fc, d1_mc;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: per instance, a frame is "active" from the accepted trigger
  // until its LEN-th valid sample at or after the window opening cycle.
  bit            m_active [2];
  int            m_open   [2];
  int            m_taken  [2];
  int            m_missed [2];
  int            m_frames [2];
  logic          m_valid  [2];
  logic          m_first  [2];
  logic          m_last   [2];
  logic          m_busy   [2];
  logic [SW-1:0] m_data   [2];
  logic [SW-1:0] exp_q0[$];
  logic [SW-1:0] exp_q1[$];

  always #5 clk = ~clk;

  capture_window #(
    .SAMPLE_WIDTH(SW), .CAPTURE_LEN(LEN), .PRE_DELAY(0), .CNT_WIDTH(CW)
  ) u_dut0 (
    .clk_in(clk), .rst_in(rst), .enable_in(en), .trigger_in(trig),
    .sample_in(smp), .sample_valid_in(sv),
    .data_out(d0_data), .valid_out(d0_valid), .first_out(d0_first),
    .last_out(d0_last), .busy_out(d0_busy),
    .frame_count_out(d0_fc), .missed_count_out(d0_mc)
  );

  capture_window #(
    .SAMPLE_WIDTH(SW), .CAPTURE_LEN(LEN), .PRE_DELAY(3), .CNT_WIDTH(CW)
  ) u_dut3 (
    .clk_in(clk), .rst_in(rst), .enable_in(en), .trigger_in(trig),
    .sample_in(smp), .sample_valid_in(sv),
    .data_out(d1_data), .valid_out(d1_valid), .first_out(d1_first),
    .last_out(d1_last), .busy_out(d1_busy),
    .frame_count_out(d1_fc), .missed_count_out(d1_mc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pre_delay_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_active[i] = 1'b0;
        m_missed[i] = 0;
        m_frames[i] = 0;
        m_valid[i]  = 1'b0;
        m_first[i]  = 1'b0;
        m_last[i]   = 1'b0;
        m_busy[i]   = 1'b0;
        m_data[i]   = '0;
        if (i == 0) exp_q0.delete(); else exp_q1.delete();
      end else begin
        m_valid[i] = 1'b0;
        m_first[i] = 1'b0;
        m_last[i]  = 1'b0;
        if (m_active[i]) begin
          if (trig) m_missed[i] = (m_missed[i] == CNT_MAX) ? CNT_MAX : m_missed[i] + 1;
          if (cyc >= m_open[i] && sv) begin
            m_taken[i]++;
            m_valid[i] = 1'b1;
            m_first[i] = (m_taken[i] == 1);
            m_last[i]  = (m_taken[i] == LEN);
            if (i == 0) exp_q0.push_back(smp); else exp_q1.push_back(smp);
            if (m_last[i]) begin
              m_active[i] = 1'b0;
              m_frames[i] = (m_frames[i] + 1) % (CNT_MAX + 1);
            end
          end
        end else if (trig && en) begin
          m_active[i] = 1'b1;
          m_open[i]   = cyc + 1 + pre_delay_of(i);
          m_taken[i]  = 0;
        end
        m_busy[i] = m_active[i];
      end
    end
    cyc++;
  end

  task automatic check_inst(input int i, input logic [SW-1:0] data, input logic valid,
                            input logic first, input logic last, input logic busy,
                            input logic [CW-1:0] fc, input logic [CW-1:0] mc);
    logic [SW-1:0] exp_d;
    int            depth;
    depth = (i == 0) ? exp_q0.size() : exp_q1.size();
    if (m_valid[i]) begin
      if (depth == 0) begin
        check($sformatf("d%0d_queue_underflow@%0d", i, cyc), 32'(depth), 32'd1);
      end else begin
        exp_d     = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        m_data[i] = exp_d;
      end
    end
    check($sformatf("d%0d_data@%0d", i, cyc), 32'(data), 32'(m_data[i]));
    check($sformatf("d%0d_valid@%0d", i, cyc), 32'(valid), 32'(m_valid[i]));
    check($sformatf("d%0d_first@%0d", i, cyc), 32'(first), 32'(m_first[i]));
    check($sformatf("d%0d_last@%0d", i, cyc), 32'(last), 32'(m_last[i]));
    check($sformatf("d%0d_busy@%0d", i, cyc), 32'(busy), 32'(m_busy[i]));
    check($sformatf("d%0d_frames@%0d", i, cyc), 32'(fc), 32'(m_frames[i]));
    check($sformatf("d%0d_missed@%0d", i, cyc), 32'(mc), 32'(m_missed[i]));
  endtask

  always @(negedge clk) begin
    check_inst(0, d0_data, d0_valid, d0_first, d0_last, d0_busy, d0_fc, d0_mc);
    check_inst(1, d1_data, d1_valid, d1_first, d1_last, d1_busy, d1_fc, d1_mc);
  end

  task automatic drive(input logic r, input logic e, input logic t, input logic v);
    @(negedge clk);
    rst  = r;
    en   = e;
    trig = t;
    sv   = v;
    smp  = SW'($urandom);
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    trig = 1'b0;
    sv   = 1'b0;
    smp  = '0;
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);

    // single frame, continuous samples
    repeat (5) drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (20) drive(1'b0, 1'b1, 1'b0, 1'b1);

    // sample gaps on every other cycle
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) drive(1'b0, 1'b1, 1'b0, 1'(k % 2));

    // trigger while disarmed
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1);

    // early second trigger plus disarm mid-frame
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (15) drive(1'b0, 1'b0, 1'b0, 1'b1);

    // reset part-way through a frame, then a clean frame
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (5) drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (20) drive(1'b0, 1'b1, 1'b0, 1'b1);

    // randomized traffic: dense triggers, gappy samples, rare resets
    repeat (4000) begin
      drive(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
    end
    repeat (20) drive(1'b0, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
